seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It holds a frame of BCD nibbles and steps one digit slot at a time through the shared 4-bit-to-7-segment decoder. It drives the active-low anode, segment and decimal-point pins, with an anti-ghosting blank interval between digits. It sits between the user datapath (counters, ALU results) and the display pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_scan_ctrl_if.sv | 26 ++
 rtl/seg7_scan_ctrl_decoder.sv | 24 ++
 rtl/seg7_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment codes (active-low
// {a,b,c,d,e,f,g}), slot phase encoding and default parameters.
package seg7_pkg;

  localparam int DEF_DIGITS       = 8;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLANK_CYCLES = 1000;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Datapath-side and pin-side signals of the scan controller, bundled for the
// user logic (master) and the controller (slave).
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS
);
  logic [4*DIGITS-1:0] value_i;
  logic                load_i;
  logic [DIGITS-1:0]   digit_en_i;
  logic [DIGITS-1:0]   dp_i;
  logic [DIGITS-1:0]   an_o;
  logic [6:0]          seg_o;
  logic                dp_o;
  logic                frame_o;

  modport master (
    output value_i, load_i, digit_en_i, dp_i,
    input  an_o, seg_o, dp_o, frame_o
  );

  modport slave (
    input  value_i, load_i, digit_en_i, dp_i,
    output an_o, seg_o, dp_o, frame_o
  );
endinterface

// File: rtl/seg7_scan_ctrl_decoder.sv
// Combinational BCD nibble to active-low segment decoder; 10..15 are dark.
module seg7_scan_ctrl_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller with anti-ghost blanking
// and tear-free frame updates. Define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = DEF_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic          clk100mhz,
  input  logic          rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]       r_slot;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend;
  logic [4*DIGITS-1:0] r_act;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_frame;

  phase_e              w_phase;
  logic                w_slot_wrap;
  logic                w_frame_wrap;
  logic [CW-1:0]       w_slot_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [4*DIGITS-1:0] w_pend_nxt;
  logic [4*DIGITS-1:0] w_act_nxt;
  logic [DIGITS-1:0]   w_an_nxt;
  logic [6:0]          w_seg_nxt;
  logic                w_dp_nxt;
  logic [3:0]          w_nib;
  logic [6:0]          w_dec;
  logic                w_lz_hit;

  assign w_nib = r_act[{r_idx, 2'b00} +: 4];

  seg7_scan_ctrl_decoder decoder (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

`ifdef SEG7_LZ_BLANK_EN
  // A digit is dark while it and every digit above it are zero; digit 0 always shows.
  // active only changes at frame wrap, so this is stable for a whole frame.
  logic [DIGITS-1:0] w_lz;
  always_comb begin : p_lz
    logic run;
    w_lz = '0;
    run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run     = run & (r_act[4*k +: 4] == 4'd0);
      w_lz[k] = run;
    end
  end
  assign w_lz_hit = w_lz[r_idx];
`else
  assign w_lz_hit = 1'b0;
`endif

  always_comb begin
    w_phase      = (r_slot < BLANK_END) ? PH_BLANK : PH_SHOW;
    w_slot_wrap  = (r_slot == SLOT_LAST);
    w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
    w_slot_nxt   = w_slot_wrap ? '0 : r_slot + CW'(1);
    w_idx_nxt    = r_idx;
    if (w_slot_wrap)
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    // A load landing on the wrap edge bypasses pending straight into active.
    w_pend_nxt = bus.load_i ? bus.value_i : r_pend;
    w_act_nxt  = w_frame_wrap ? w_pend_nxt : r_act;
    w_an_nxt   = '1;
    w_seg_nxt  = SEG_OFF;
    w_dp_nxt   = 1'b1;
    if (w_phase == PH_SHOW) begin
      w_an_nxt[r_idx] = ~bus.digit_en_i[r_idx];
      w_seg_nxt       = w_lz_hit ? SEG_OFF : w_dec;
      w_dp_nxt        = ~bus.dp_i[r_idx];
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      r_slot  <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      r_an    <= '1;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_slot  <= w_slot_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
      r_act   <= w_act_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_frame <= w_frame_wrap;
    end
  end

  assign bus.an_o    = r_an;
  assign bus.seg_o   = r_seg;
  assign bus.dp_o    = r_dp;
  assign bus.frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboarded bench for seg7_scan_ctrl: a time-based reference model queues the
// expected pins every edge; a negedge checker pops and compares.
module tb_seg7_scan_ctrl;
  localparam int D     = 8;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = D * R;

  logic clk100mhz = 1'b0;
  logic rst       = 1'b1;

  seg7_scan_ctrl_if #(.DIGITS(D)) bus ();

  seg7_scan_ctrl #(
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk100mhz = ~clk100mhz;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [D-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic ref_lz(input logic [4*D-1:0] v, input int d);
    logic en_lz;
`ifdef SEG7_LZ_BLANK_EN
    en_lz = 1'b1;
`else
    en_lz = 1'b0;
`endif
    if (!en_lz || d == 0) return 1'b0;
    for (int j = d; j < D; j++)
      if (v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: state is the count of edges since reset.
  int unsigned       m_k;
  logic [4*D-1:0]    m_pend;
  logic [4*D-1:0]    m_act;

  always @(posedge clk100mhz) begin : p_model
    automatic exp_t e;
    automatic int slot;
    automatic int idx;
    e = '{an: '1, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
    if (rst) begin
      m_k    <= 0;
      m_pend <= '0;
      m_act  <= '0;
    end else begin
      slot    = int'(m_k % R);
      idx     = int'((m_k / R) % D);
      e.frame = ((m_k % FRAME) == FRAME - 1);
      if (slot >= B) begin
        if (bus.digit_en_i[idx]) e.an[idx] = 1'b0;
        e.seg = ref_lz(m_act, idx) ? 7'h7F : ref_seg(m_act[4*idx +: 4]);
        e.dp  = ~bus.dp_i[idx];
      end
      if (bus.load_i) m_pend <= bus.value_i;
      if (e.frame) m_act <= bus.load_i ? bus.value_i : m_pend;
      m_k <= m_k + 1;
    end
    sb.push_back(e);
  end

  always @(negedge clk100mhz) begin : p_check
    automatic exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_an",    32'(bus.an_o),    32'(e.an));
      chk("sb_seg",   32'(bus.seg_o),   32'(e.seg));
      chk("sb_dp",    32'(bus.dp_o),    32'(e.dp));
      chk("sb_frame", 32'(bus.frame_o), 32'(e.frame));
    end
  end

  task automatic wait_frame(input string tag);
    int c = 0;
    do begin @(negedge clk100mhz); c++; end
    while (bus.frame_o !== 1'b1 && c < 200);
    if (bus.frame_o !== 1'b1) chk({tag, "_timeout"}, 32'(bus.frame_o), 32'd1);
  endtask

  task automatic wait_an(input logic [D-1:0] want, input string tag);
    int c = 0;
    do begin @(negedge clk100mhz); c++; end
    while (bus.an_o !== want && c < 200);
    if (bus.an_o !== want) chk({tag, "_timeout"}, 32'(bus.an_o), 32'(want));
  endtask

  task automatic load(input logic [4*D-1:0] v);
    bus.value_i = v;
    bus.load_i  = 1'b1;
    @(negedge clk100mhz);
    bus.load_i  = 1'b0;
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int first;
    int c;
    int v_an, v_dp, seen_dp0, seen_a;
    bus.value_i    = '0;
    bus.load_i     = 1'b0;
    bus.digit_en_i = '1;
    bus.dp_i       = '0;

    // Reset held for three edges
    repeat (3) @(negedge clk100mhz);
    chk("rst_an",    32'(bus.an_o),    32'hFF);
    chk("rst_seg",   32'(bus.seg_o),   32'h7F);
    chk("rst_dp",    32'(bus.dp_o),    32'd1);
    chk("rst_frame", 32'(bus.frame_o), 32'd0);
    rst   = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk100mhz);
      if (bus.an_o !== 8'hFF) begin first = i; break; end
    end
    chk("first_show_cycle", 32'(first), 32'd2);
    chk("first_show_an",    32'(bus.an_o), 32'hFE);

    // Scan of a full value
    load(32'h76543210);
    wait_frame("scan_f0");
    c = 0;
    do begin @(negedge clk100mhz); c++; end
    while (bus.frame_o !== 1'b1 && c < 100);
    chk("frame_period", 32'(c), 32'd32);
    wait_an(8'hFD, "d1");
    chk("d1_seg", 32'(bus.seg_o), 32'(7'b1001111));
    wait_an(8'h7F, "d7");
    chk("d7_seg", 32'(bus.seg_o), 32'(7'b0001111));

    // Mid-frame load must not tear
    wait_frame("tear_f0");
    wait_an(8'hF7, "tear_d3");
    load(32'h11111111);
    wait_an(8'hBF, "tear_d6");
    chk("tear_old", 32'(bus.seg_o), 32'(7'b0100000));
    wait_frame("tear_f1");
    wait_an(8'hFE, "tear_d0");
    chk("tear_new", 32'(bus.seg_o), 32'(7'b1001111));

    // Load exactly on the wrap edge shows immediately
    wait_frame("wrap_f0");
    repeat (31) @(negedge clk100mhz);
    load(32'h22222222);
    chk("wrap_frame", 32'(bus.frame_o), 32'd1);
    repeat (2) @(negedge clk100mhz);
    chk("wrap_now_an",  32'(bus.an_o),  32'hFE);
    chk("wrap_now_seg", 32'(bus.seg_o), 32'(7'b0010010));

    // Enables, decimal points and an out-of-range nibble
    bus.digit_en_i = 8'h0F;
    bus.dp_i       = 8'h01;
    load(32'h7654321A);
    wait_frame("en_f0");
    v_an = 0; v_dp = 0; seen_dp0 = 0; seen_a = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk100mhz);
      if (bus.an_o[7:4] !== 4'hF) v_an++;
      if (bus.dp_o === 1'b0 && bus.an_o !== 8'hFE) v_dp++;
      if (bus.dp_o === 1'b0 && bus.an_o === 8'hFE) seen_dp0++;
      if (bus.an_o === 8'hFE && bus.seg_o === 7'h7F) seen_a++;
    end
    chk("en_hi_never_low", 32'(v_an), 32'd0);
    chk("dp_only_d0",      32'(v_dp), 32'd0);
    chk("dp_d0_seen",      32'(seen_dp0 > 0), 32'd1);
    chk("nib_a_dark",      32'(seen_a > 0), 32'd1);

    // Reset during digit 5 SHOW, with a load that must be ignored
    bus.digit_en_i = '1;
    bus.dp_i       = '0;
    wait_an(8'hDF, "mid_d5");
    rst         = 1'b1;
    bus.value_i = 32'h99999999;
    bus.load_i  = 1'b1;
    @(negedge clk100mhz);
    chk("mid_rst_an",    32'(bus.an_o),    32'hFF);
    chk("mid_rst_seg",   32'(bus.seg_o),   32'h7F);
    chk("mid_rst_dp",    32'(bus.dp_o),    32'd1);
    chk("mid_rst_frame", 32'(bus.frame_o), 32'd0);
    rst        = 1'b0;
    bus.load_i = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk100mhz);
      if (bus.an_o !== 8'hFF) begin first = i; break; end
    end
    chk("resume_cycle", 32'(first), 32'd2);
    chk("resume_an",    32'(bus.an_o),  32'hFE);
    chk("resume_seg",   32'(bus.seg_o), 32'(7'b0000001));

    // Leading zeros
    load(32'h00000405);
    wait_frame("lz_f0");
    wait_an(8'hFB, "lz_d2");
    chk("lz_d2_seg", 32'(bus.seg_o), 32'(7'b1001100));
    wait_an(8'hEF, "lz_d4");
`ifdef SEG7_LZ_BLANK_EN
    chk("lz_d4_seg", 32'(bus.seg_o), 32'h7F);
`else
    chk("lz_d4_seg", 32'(bus.seg_o), 32'(7'b0000001));
`endif
    wait_frame("lz_f1");
    wait_an(8'hFD, "lz_d1");
    chk("lz_d1_seg", 32'(bus.seg_o), 32'(7'b0000001));
    wait_an(8'hFE, "lz_d0");
    chk("lz_d0_seg", 32'(bus.seg_o), 32'(7'b0100100));
    load(32'h00000000);
    wait_frame("lz0_f0");
    wait_an(8'hFE, "lz0_d0");
    chk("lz0_d0_seg", 32'(bus.seg_o), 32'(7'b0000001));

    repeat (4) @(negedge clk100mhz);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
